// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter: two-requester round-robin front end to a Y86-style ALU.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_setcc,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_setcc,
   output logic             req1_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_value,
   output logic             res_id,
   output logic [2:0]       cc
);

   localparam logic [1:0] c_OP_ADD = 2'd0;
   localparam logic [1:0] c_OP_SUB = 2'd1;
   localparam logic [1:0] c_OP_AND = 2'd2;
   localparam logic [1:0] c_OP_XOR = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic             r_ptr;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_setcc;
   logic             r_id;
   logic             r_res_valid;
   logic [WIDTH-1:0] r_res_value;
   logic             r_res_id;
   logic [2:0]       r_cc;

   logic             w_idle;
   logic             w_gnt0;
   logic             w_gnt1;
   logic [WIDTH-1:0] w_result;
   logic             w_of;
   logic [2:0]       w_cc;

   // Preferred requester wins a tie; a lone requester always wins.
   assign w_idle = (r_state == IDLE) && rst_n;
   assign w_gnt0 = w_idle && req0_valid && (!req1_valid || (r_ptr == 1'b0));
   assign w_gnt1 = w_idle && req1_valid && (!req0_valid || (r_ptr == 1'b1));

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   always_comb begin
      w_result = '0;
      w_of     = 1'b0;
      case (r_op)
         c_OP_ADD: begin
            w_result = r_b + r_a;
            w_of     = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_result[WIDTH-1] != r_a[WIDTH-1]);
         end
         c_OP_SUB: begin
            // Y86 subq computes rB - rA
            w_result = r_b - r_a;
            w_of     = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_result[WIDTH-1] != r_b[WIDTH-1]);
         end
         c_OP_AND: w_result = r_a & r_b;
         c_OP_XOR: w_result = r_a ^ r_b;
         default:  w_result = '0;
      endcase
      w_cc = {(w_result == '0), w_result[WIDTH-1], w_of};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ptr       <= 1'b0;
         r_op        <= 2'd0;
         r_a         <= '0;
         r_b         <= '0;
         r_setcc     <= 1'b0;
         r_id        <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_value <= '0;
         r_res_id    <= 1'b0;
         r_cc        <= 3'b100;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt0) begin
                  r_op    <= req0_op;
                  r_a     <= req0_a;
                  r_b     <= req0_b;
                  r_setcc <= req0_setcc;
                  r_id    <= 1'b0;
                  r_ptr   <= 1'b1;
                  r_state <= EXEC;
               end else if (w_gnt1) begin
                  r_op    <= req1_op;
                  r_a     <= req1_a;
                  r_b     <= req1_b;
                  r_setcc <= req1_setcc;
                  r_id    <= 1'b1;
                  r_ptr   <= 1'b0;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               r_res_value <= w_result;
               r_res_id    <= r_id;
               r_res_valid <= 1'b1;
               if (r_setcc) begin
                  r_cc <= w_cc;
               end
               r_state <= DONE;
            end
            DONE: begin
               if (res_ready) begin
                  r_res_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign res_valid = r_res_valid;
   assign res_value = r_res_value;
   assign res_id    = r_res_id;
   assign cc        = r_cc;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter: directed self-checking bench for alu_arbiter.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0;
   logic [1:0]   req0_op = 2'd0;
   logic [W-1:0] req0_a = '0;
   logic [W-1:0] req0_b = '0;
   logic         req0_setcc = 1'b0;
   logic         req0_ready;
   logic         req1_valid = 1'b0;
   logic [1:0]   req1_op = 2'd0;
   logic [W-1:0] req1_a = '0;
   logic [W-1:0] req1_b = '0;
   logic         req1_setcc = 1'b0;
   logic         req1_ready;
   logic         res_valid;
   logic         res_ready = 1'b0;
   logic [W-1:0] res_value;
   logic         res_id;
   logic [2:0]   cc;

   int n_cmp = 0;
   int n_err = 0;

   alu_arbiter #(.WIDTH(W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_op    (req0_op),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_setcc (req0_setcc),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_op    (req1_op),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_setcc (req1_setcc),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_value  (res_value),
      .res_id     (res_id),
      .cc         (cc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   // Single requester issues one op; result is checked and drained.
   task automatic issue(input string tag, input logic id, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b, input logic sc,
                        input logic [W-1:0] exp_v, input logic [2:0] exp_cc);
      if (id == 1'b0) begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_setcc = sc;
      end else begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_setcc = sc;
      end
      #1;
      chk({tag, "_rdy"}, {63'd0, (id ? req1_ready : req0_ready)}, 64'd1);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      chk({tag, "_exec_vld"}, {63'd0, res_valid}, 64'd0);
      tick;
      chk({tag, "_vld"}, {63'd0, res_valid}, 64'd1);
      chk({tag, "_val"}, res_value, exp_v);
      chk({tag, "_id"}, {63'd0, res_id}, {63'd0, id});
      chk({tag, "_cc"}, {61'd0, cc}, {61'd0, exp_cc});
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
      chk({tag, "_drain"}, {63'd0, res_valid}, 64'd0);
   endtask

   initial begin
      int g_cnt;
      int r_cnt;

      // Reset with a requester already pending: no ready while in reset.
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      tick;
      chk("rst_rdy0", {63'd0, req0_ready}, 64'd0);
      chk("rst_rdy1", {63'd0, req1_ready}, 64'd0);
      tick;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      chk("rst_vld", {63'd0, res_valid}, 64'd0);
      chk("rst_val", res_value, 64'd0);
      chk("rst_id", {63'd0, res_id}, 64'd0);
      chk("rst_cc", {61'd0, cc}, 64'd4);
      rst_n = 1'b1;
      tick;

      issue("xor0", 1'b0, 2'd3, 64'b100110, 64'b110001, 1'b1, 64'b010111, 3'b000);
      issue("add1", 1'b1, 2'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1,
            64'h8000_0000_0000_0000, 3'b011);
      issue("subz", 1'b0, 2'd1, 64'h2D, 64'h2D, 1'b1, 64'd0, 3'b100);
      issue("subn", 1'b0, 2'd1, 64'd1, 64'd3, 1'b0, 64'd2, 3'b100);
      issue("and1", 1'b1, 2'd2, 64'hFF00, 64'h0FF0, 1'b1, 64'h0F00, 3'b000);

      // Pointer now prefers requester 0; contend and stall the consumer.
      req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd5; req0_b = 64'd7; req0_setcc = 1'b1;
      req1_valid = 1'b1; req1_op = 2'd3; req1_a = 64'd1; req1_b = 64'd1; req1_setcc = 1'b1;
      #1;
      chk("hold_rdy0", {63'd0, req0_ready}, 64'd1);
      chk("hold_rdy1", {63'd0, req1_ready}, 64'd0);
      tick;
      req0_a = 64'd100;
      tick;
      for (int i = 0; i < 5; i++) begin
         chk("hold_vld", {63'd0, res_valid}, 64'd1);
         chk("hold_val", res_value, 64'd12);
         chk("hold_id", {63'd0, res_id}, 64'd0);
         chk("hold_cc", {61'd0, cc}, 64'd0);
         chk("hold_nordy", {62'd0, req0_ready, req1_ready}, 64'd0);
         tick;
      end
      res_ready = 1'b1;
      #1;
      chk("hold_last_vld", {63'd0, res_valid}, 64'd1);
      tick;
      res_ready = 1'b0;
      chk("hold_done", {63'd0, res_valid}, 64'd0);
      chk("hold_next_rdy1", {63'd0, req1_ready}, 64'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;

      // Continuous contention from reset: grants and results alternate 0,1,0,1.
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready = 1'b1;
      g_cnt = 0;
      r_cnt = 0;
      for (int i = 0; i < 40 && r_cnt < 4; i++) begin
         #1;
         chk("rr_excl", {63'd0, req0_ready & req1_ready}, 64'd0);
         if (req0_ready || req1_ready) begin
            chk("rr_gnt", {63'd0, req1_ready}, 64'(g_cnt % 2));
            g_cnt++;
         end
         if (res_valid) begin
            chk("rr_id", {63'd0, res_id}, 64'(r_cnt % 2));
            r_cnt++;
         end
         tick;
      end
      chk("rr_results", 64'(r_cnt), 64'd4);
      chk("rr_grants", 64'(g_cnt >= 4), 64'd1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready = 1'b0;
      tick;
      tick;
      tick;
      res_ready = 1'b1;
      tick;
      tick;
      res_ready = 1'b0;

      // Reset while EXEC: op discarded, pointer back to requester 0.
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      issue("pre0", 1'b0, 2'd3, 64'd3, 64'd3, 1'b1, 64'd0, 3'b100);
      req0_valid = 1'b1; req0_op = 2'd0; req0_a = 64'd1; req0_b = 64'd1; req0_setcc = 1'b1;
      tick;
      req0_valid = 1'b0;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("rexec_vld", {63'd0, res_valid}, 64'd0);
      chk("rexec_cc", {61'd0, cc}, 64'd4);
      tick;
      chk("rexec_vld2", {63'd0, res_valid}, 64'd0);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("rexec_rdy0", {63'd0, req0_ready}, 64'd1);
      chk("rexec_rdy1", {63'd0, req1_ready}, 64'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
